// File: rtl/mem_access_pkg.sv
// Shared encodings for the core-side memory access unit: access sizes,
// FSM state codes and the alignment check used at request acceptance.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StRdIssue = 3'd1;
  localparam logic [2:0] StRdWait  = 3'd2;
  localparam logic [2:0] StWrWait  = 3'd3;
  localparam logic [2:0] StErr     = 3'd4;

  // True for a misaligned half/word or the illegal size encoding.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] offset);
    unique case (size)
      SIZE_BYTE: bad_access = 1'b0;
      SIZE_HALF: bad_access = offset[0];
      SIZE_WORD: bad_access = (offset != 2'b00);
      default:   bad_access = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store mask and data shift, load extract and extension.
// Purely combinational so the core's forwarding path can reuse it.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic        ext_b;
  logic        ext_h;

  assign wdata_o = wdata_i << {offset_i, 3'b000};
  assign shifted = rdata_i >> {offset_i, 3'b000};
  assign ext_b   = ~unsigned_i & shifted[7];
  assign ext_h   = ~unsigned_i & shifted[15];

  always_comb begin
    be_o    = 4'b0000;
    rdata_o = 32'h0;
    unique case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << offset_i;
        rdata_o = {{24{ext_b}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        be_o    = 4'b0011 << offset_i;
        rdata_o = {{16{ext_h}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        be_o    = 4'b1111;
        rdata_o = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Core-side initiator for the Cache word port: turns byte/half/word loads and
// stores into word-aligned Cache accesses with registered Cache-side outputs.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned ADDR_BITWIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDR_BITWIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_error,
  output logic [ADDR_BITWIDTH-1:0] c_address,
  output logic [31:0]              c_data_in,
  output logic [3:0]               c_write_enable,
  input  logic [31:0]              c_data_out,
  input  logic                     c_data_out_ready,
  input  logic                     c_busy
);

  logic [2:0]               state_q, state_d;
  logic [1:0]               size_q, size_d;
  logic                     uns_q, uns_d;
  logic [1:0]               off_q, off_d;
  logic [ADDR_BITWIDTH-1:0] c_address_q, c_address_d;
  logic [31:0]              c_data_in_q, c_data_in_d;
  logic [3:0]               c_we_q, c_we_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_error_q, resp_error_d;
  logic [31:0]              resp_rdata_q, resp_rdata_d;

  logic                     idle;
  logic [1:0]               lane_size;
  logic [1:0]               lane_off;
  logic [3:0]               lane_be;
  logic [31:0]              lane_wdata;
  logic [31:0]              lane_rdata;

  // Store lanes come from the live request in IDLE; load extract uses the latched request.
  assign idle      = (state_q == StIdle);
  assign lane_size = idle ? req_size : size_q;
  assign lane_off  = idle ? req_addr[1:0] : off_q;

  mem_lane_align u_lane_align (
    .size_i     (lane_size),
    .offset_i   (lane_off),
    .unsigned_i (uns_q),
    .wdata_i    (req_wdata),
    .rdata_i    (c_data_out),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata)
  );

  always_comb begin
    state_d      = state_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    c_address_d  = c_address_q;
    c_data_in_d  = c_data_in_q;
    c_we_d       = c_we_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          size_d = req_size;
          uns_d  = req_unsigned;
          off_d  = req_addr[1:0];
          if (bad_access(req_size, req_addr[1:0])) begin
            state_d = StErr;
          end else begin
            c_address_d = {req_addr[ADDR_BITWIDTH-1:2], 2'b00};
            if (req_write) begin
              c_we_d      = lane_be;
              c_data_in_d = lane_wdata;
              state_d     = StWrWait;
            end else begin
              c_we_d  = 4'b0000;
              state_d = StRdIssue;
            end
          end
        end
      end
      // data_out_ready may still describe the previous address here.
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        if (c_data_out_ready && !c_busy) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = lane_rdata;
          state_d      = StIdle;
        end
      end
      StWrWait: begin
        if (!c_busy) begin
          c_we_d       = 4'b0000;
          resp_valid_d = 1'b1;
          state_d      = StIdle;
        end
      end
      StErr: begin
        resp_valid_d = 1'b1;
        resp_error_d = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      c_address_q  <= '0;
      c_data_in_q  <= 32'h0;
      c_we_q       <= 4'b0000;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      c_address_q  <= c_address_d;
      c_data_in_q  <= c_data_in_d;
      c_we_q       <= c_we_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready      = idle;
  assign resp_valid     = resp_valid_q;
  assign resp_error     = resp_error_q;
  assign resp_rdata     = resp_rdata_q;
  assign c_address      = c_address_q;
  assign c_data_in      = c_data_in_q;
  assign c_write_enable = c_we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a small word-memory standing in for
// the Cache; busy/ready are driven by each scenario.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic [31:0] c_address, c_data_in, c_data_out;
  logic [3:0]  c_write_enable;
  logic        c_data_out_ready, c_busy;

  logic [31:0] mem [32];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITWIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_unsigned     (req_unsigned),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .c_address        (c_address),
    .c_data_in        (c_data_in),
    .c_write_enable   (c_write_enable),
    .c_data_out       (c_data_out),
    .c_data_out_ready (c_data_out_ready),
    .c_busy           (c_busy)
  );

  // Cache stand-in: masked write at a clock edge when not busy.
  assign c_data_out = mem[c_address[6:2]];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
      mem[2] <= 32'hAB4C3E6F;
      mem[3] <= 32'h9D8E2F17;
      mem[4] <= 32'hD5B8A9C4;
      mem[8] <= 32'h2F5E3C7A;
    end else if (!c_busy) begin
      for (int b = 0; b < 4; b++)
        if (c_write_enable[b]) mem[c_address[6:2]][8*b +: 8] <= c_data_in[8*b +: 8];
    end
  end

  // Called at a negedge; request is accepted at the following posedge.
  task automatic issue(input logic w, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_write = 1'b0;
  endtask

  // Negedges waited until resp_valid is seen; -1 on timeout.
  task automatic wait_resp(output int lat, output logic [31:0] rd, output logic er);
    lat = -1; rd = 32'h0; er = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (resp_valid === 1'b1) begin
        lat = k; rd = resp_rdata; er = resp_error;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    checks++; if (resp_valid !== 1'b0 || resp_error !== 1'b0 || resp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_resp got v%b e%b %h want 0", resp_valid, resp_error, resp_rdata); end
    checks++; if (c_address !== 32'h0 || c_write_enable !== 4'h0 || c_data_in !== 32'h0) begin
      errors++; $display("FAIL reset_cache got %h %b %h want 0", c_address, c_write_enable, c_data_in); end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load_miss();
    int lat; logic [31:0] rd; logic er;
    c_busy = 1'b1; c_data_out_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'd16, 32'h0);
    checks++; if (c_address !== 32'd16) begin errors++; $display("FAIL miss_addr got %h want 10", c_address); end
    repeat (4) begin
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL miss_early_resp got %b want 0", resp_valid); end
      @(negedge clk);
    end
    c_busy = 1'b0; c_data_out_ready = 1'b1;
    wait_resp(lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL miss_lat got %0d want 1", lat); end
    checks++; if (rd !== 32'hD5B8A9C4 || er !== 1'b0) begin
      errors++; $display("FAIL miss_data got %h e%b want D5B8A9C4 e0", rd, er); end
  endtask

  task automatic test_load_ext();
    int lat; logic [31:0] rd; logic er;
    logic [31:0] a_v [3]; logic [1:0] s_v [3]; logic u_v [3]; logic [31:0] e_v [3];
    a_v[0] = 32'd9;  s_v[0] = 2'd0; u_v[0] = 1'b1; e_v[0] = 32'h0000003E;
    a_v[1] = 32'd11; s_v[1] = 2'd0; u_v[1] = 1'b0; e_v[1] = 32'hFFFFFFAB;
    a_v[2] = 32'd10; s_v[2] = 2'd1; u_v[2] = 1'b0; e_v[2] = 32'hFFFFAB4C;
    for (int i = 0; i < 3; i++) begin
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL ext_ready[%0d] got %b want 1", i, req_ready); end
      issue(1'b0, s_v[i], u_v[i], a_v[i], 32'h0);
      wait_resp(lat, rd, er);
      checks++; if (lat !== 2) begin errors++; $display("FAIL ext_lat[%0d] got %0d want 2", i, lat); end
      checks++; if (rd !== e_v[i] || er !== 1'b0) begin
        errors++; $display("FAIL ext_data[%0d] got %h e%b want %h e0", i, rd, er, e_v[i]); end
    end
  endtask

  task automatic test_store();
    int lat; logic [31:0] rd; logic er;
    issue(1'b1, 2'd0, 1'b0, 32'd8, 32'h000000AD);
    checks++; if (c_write_enable !== 4'b0001 || c_data_in[7:0] !== 8'hAD || c_address !== 32'd8) begin
      errors++; $display("FAIL stb_lanes got %b %h @%h want 0001 AD @8", c_write_enable, c_data_in, c_address); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stb_busy_ready got %b want 0", req_ready); end
    wait_resp(lat, rd, er);
    checks++; if (lat !== 1 || rd !== 32'h0) begin errors++; $display("FAIL stb_ack got lat%0d %h want lat1 0", lat, rd); end
    issue(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    wait_resp(lat, rd, er);
    checks++; if (lat !== 2 || rd !== 32'hAB4C3EAD) begin
      errors++; $display("FAIL stb_readback got lat%0d %h want lat2 AB4C3EAD", lat, rd); end
    issue(1'b1, 2'd1, 1'b0, 32'd10, 32'h0000FEEF);
    checks++; if (c_write_enable !== 4'b1100 || c_data_in !== 32'hFEEF0000) begin
      errors++; $display("FAIL sth_lanes got %b %h want 1100 FEEF0000", c_write_enable, c_data_in); end
    wait_resp(lat, rd, er);
    checks++; if (lat !== 1) begin errors++; $display("FAIL sth_ack got lat%0d want 1", lat); end
    issue(1'b0, 2'd2, 1'b0, 32'd8, 32'h0);
    wait_resp(lat, rd, er);
    checks++; if (rd !== 32'hFEEF3EAD) begin errors++; $display("FAIL sth_readback got %h want FEEF3EAD", rd); end
  endtask

  task automatic test_error();
    int lat; logic [31:0] rd; logic er;
    @(negedge clk);
    issue(1'b0, 2'd2, 1'b0, 32'd6, 32'h0);
    checks++; if (c_write_enable !== 4'h0 || c_address !== 32'd8) begin
      errors++; $display("FAIL err_ld_nocache got %b @%h want 0000 @8", c_write_enable, c_address); end
    wait_resp(lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL err_ld_resp got lat%0d e%b %h want lat1 e1 0", lat, er, rd); end
    issue(1'b1, 2'd1, 1'b0, 32'd13, 32'h0000FFFF);
    checks++; if (c_write_enable !== 4'h0 || c_address !== 32'd8) begin
      errors++; $display("FAIL err_st_nocache got %b @%h want 0000 @8", c_write_enable, c_address); end
    wait_resp(lat, rd, er);
    checks++; if (lat !== 1 || er !== 1'b1) begin errors++; $display("FAIL err_st_resp got lat%0d e%b want lat1 e1", lat, er); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL err_pulse got %b want 0", resp_valid); end
  endtask

  task automatic test_store_miss();
    int lat; logic [31:0] rd; logic er;
    c_busy = 1'b1;
    issue(1'b1, 2'd2, 1'b0, 32'd64, 32'hABCDEF12);
    checks++; if (c_address !== 32'd64 || c_data_in !== 32'hABCDEF12) begin
      errors++; $display("FAIL stw_issue got @%h %h want @40 ABCDEF12", c_address, c_data_in); end
    repeat (3) begin
      checks++; if (c_write_enable !== 4'b1111 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL stw_hold got %b v%b want 1111 v0", c_write_enable, resp_valid); end
      @(negedge clk);
    end
    c_busy = 1'b0;
    wait_resp(lat, rd, er);
    checks++; if (lat !== 1 || c_write_enable !== 4'h0) begin
      errors++; $display("FAIL stw_commit got lat%0d %b want lat1 0000", lat, c_write_enable); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stw_pulse got %b want 0", resp_valid); end
    issue(1'b0, 2'd2, 1'b0, 32'd64, 32'h0);
    wait_resp(lat, rd, er);
    checks++; if (lat !== 2 || rd !== 32'hABCDEF12) begin
      errors++; $display("FAIL stw_readback got lat%0d %h want lat2 ABCDEF12", lat, rd); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] rd; logic er;
    @(negedge clk);
    c_busy = 1'b1; c_data_out_ready = 1'b0;
    issue(1'b0, 2'd2, 1'b0, 32'd32, 32'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (c_address !== 32'h0 || c_write_enable !== 4'h0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid got @%h %b v%b r%b want 0 0 0 1", c_address, c_write_enable, resp_valid, req_ready); end
    @(negedge clk);
    rst_n = 1'b1; c_busy = 1'b0; c_data_out_ready = 1'b1;
    repeat (4) begin
      checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        errors++; $display("FAIL rst_no_resp got v%b r%b want v0 r1", resp_valid, req_ready); end
      @(negedge clk);
    end
    issue(1'b0, 2'd2, 1'b0, 32'd32, 32'h0);
    wait_resp(lat, rd, er);
    checks++; if (lat !== 2 || rd !== 32'h2F5E3C7A) begin
      errors++; $display("FAIL rst_reload got lat%0d %h want lat2 2F5E3C7A", lat, rd); end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; c_busy = 1'b0; c_data_out_ready = 1'b1;
    test_reset();
    test_load_miss();
    test_load_ext();
    test_store();
    test_error();
    test_store_miss();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
